frame_header_parser: RTL and testbench

FRAME_HEADER_PARSER -- requirements
Module: frame_header_parser

---
 rtl/prores_pkg.sv | 33 +++
 rtl/frame_header_parser.sv | 192 +++++++++++++++++++
 tb/tb_frame_header_parser.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/prores_pkg.sv
// prores_pkg -- shared constants and types for the ProRes frame header parser.
//   ICPF_SIG        : frame signature expected in header bytes 4..7
//   FIXED_LEN       : number of bytes in the fixed part of the header
//   QMAT_LEN        : number of bytes in one quantisation matrix
//   state_e / err_e : parser state and error cause encodings
//   exp_hdr_size()  : header size implied by the two matrix load flags
package prores_pkg;

  localparam logic [31:0] ICPF_SIG  = 32'h69637066;
  localparam int          FIXED_LEN = 28;
  localparam int          QMAT_LEN  = 64;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FIXED  = 3'd1,
    ST_LUMA   = 3'd2,
    ST_CHROMA = 3'd3,
    ST_DONE   = 3'd4,
    ST_ERROR  = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_BAD_SIG  = 2'd1,
    ERR_BAD_SIZE = 2'd2
  } err_e;

  // 20 fixed bytes after frame_size/signature, plus 64 per loaded matrix.
  function automatic logic [15:0] exp_hdr_size(input logic ll, input logic lc);
    return 16'd20 + (ll ? 16'd64 : 16'd0) + (lc ? 16'd64 : 16'd0);
  endfunction

endpackage

// File: rtl/frame_header_parser.sv
// frame_header_parser -- byte-serial ProRes frame header parser.
// A start pulse arms the parser; it then consumes the 28-byte fixed header,
// optionally the 64-byte luma and chroma quantisation matrices, and pulses
// header_valid, or latches a sticky error (bad signature / bad header size).
// Ports:
//   clock, reset_n          : clock, asynchronous active-low reset
//   start                   : one-cycle arm pulse (restarts from any state)
//   in_valid/in_data/in_ready : byte stream handshake
//   frame_size .. matrix_coefficients : decoded header fields
//   qmat_we/sel/addr/data   : matrix byte write port (sel 0 luma, 1 chroma)
//   header_valid            : one-cycle pulse on successful parse
//   header_error/error_code : sticky error flag and cause
// Build option: FRAME_HEADER_PARSER_QMAT_EN enables the qmat write port;
// when undefined the matrix bytes are consumed and dropped, port tied to 0.
module frame_header_parser
  import prores_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic [31:0] frame_size,
  output logic [15:0] horizontal,
  output logic [15:0] vertical,
  output logic [1:0]  chroma_format,
  output logic [1:0]  interlace_mode,
  output logic [3:0]  aspect_ratio_information,
  output logic [3:0]  frame_rate_code,
  output logic [3:0]  alpha_channel_type,
  output logic [7:0]  color_primaries,
  output logic [7:0]  transfer_characteristic,
  output logic [7:0]  matrix_coefficients,
  output logic        qmat_we,
  output logic        qmat_sel,
  output logic [5:0]  qmat_addr,
  output logic [7:0]  qmat_data,
  output logic        header_valid,
  output logic        header_error,
  output logic [1:0]  error_code
);

  state_e      state;
  err_e        err_q;
  logic [6:0]  byte_cnt;
  logic [23:0] sh;          // previous three consumed bytes, newest in [7:0]
  logic [15:0] hdr_size;
  logic        load_luma;
  logic        load_chroma;
  logic        accept;
  logic [31:0] word;        // 4-byte field ending with the current byte
  logic [15:0] half;        // 2-byte field ending with the current byte

  assign in_ready = ((state == ST_FIXED) || (state == ST_LUMA) ||
                     (state == ST_CHROMA)) && !start;
  assign accept   = in_valid && in_ready;
  assign word     = {sh, in_data};
  assign half     = {sh[7:0], in_data};
  assign error_code = err_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state                    <= ST_IDLE;
      err_q                    <= ERR_NONE;
      byte_cnt                 <= '0;
      sh                       <= '0;
      hdr_size                 <= '0;
      load_luma                <= 1'b0;
      load_chroma              <= 1'b0;
      frame_size               <= '0;
      horizontal               <= '0;
      vertical                 <= '0;
      chroma_format            <= '0;
      interlace_mode           <= '0;
      aspect_ratio_information <= '0;
      frame_rate_code          <= '0;
      alpha_channel_type       <= '0;
      color_primaries          <= '0;
      transfer_characteristic  <= '0;
      matrix_coefficients      <= '0;
      header_valid             <= 1'b0;
      header_error             <= 1'b0;
    end else begin
      header_valid <= 1'b0;
      if (start) begin
        state        <= ST_FIXED;
        byte_cnt     <= '0;
        header_error <= 1'b0;
        err_q        <= ERR_NONE;
      end else if (accept) begin
        sh       <= {sh[15:0], in_data};
        byte_cnt <= byte_cnt + 7'd1;
        case (state)
          ST_FIXED: begin
            case (byte_cnt)
              7'd3:  frame_size <= word;
              7'd7: begin
                if (word != ICPF_SIG) begin
                  state        <= ST_ERROR;
                  header_error <= 1'b1;
                  err_q        <= ERR_BAD_SIG;
                end
              end
              7'd9:  hdr_size   <= half;
              7'd17: horizontal <= half;
              7'd19: vertical   <= half;
              7'd20: begin
                chroma_format  <= in_data[7:6];
                interlace_mode <= in_data[3:2];
              end
              7'd21: begin
                aspect_ratio_information <= in_data[7:4];
                frame_rate_code          <= in_data[3:0];
              end
              7'd22: color_primaries         <= in_data;
              7'd23: transfer_characteristic <= in_data;
              7'd24: matrix_coefficients     <= in_data;
              7'd25: alpha_channel_type      <= in_data[3:0];
              7'(FIXED_LEN - 1): begin
                load_luma   <= in_data[1];
                load_chroma <= in_data[0];
                byte_cnt    <= '0;
                if (hdr_size != exp_hdr_size(in_data[1], in_data[0])) begin
                  state        <= ST_ERROR;
                  header_error <= 1'b1;
                  err_q        <= ERR_BAD_SIZE;
                end else if (in_data[1]) begin
                  state <= ST_LUMA;
                end else if (in_data[0]) begin
                  state <= ST_CHROMA;
                end else begin
                  state        <= ST_DONE;
                  header_valid <= 1'b1;
                end
              end
              default: ;
            endcase
          end
          ST_LUMA: begin
            if (byte_cnt == 7'(QMAT_LEN - 1)) begin
              byte_cnt <= '0;
              if (load_chroma) begin
                state <= ST_CHROMA;
              end else begin
                state        <= ST_DONE;
                header_valid <= 1'b1;
              end
            end
          end
          ST_CHROMA: begin
            if (byte_cnt == 7'(QMAT_LEN - 1)) begin
              byte_cnt     <= '0;
              state        <= ST_DONE;
              header_valid <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef FRAME_HEADER_PARSER_QMAT_EN
  // Matrix bytes are forwarded one cycle after acceptance; sel/addr/data
  // hold their last value between writes.
  logic qmat_hit;
  assign qmat_hit = accept && ((state == ST_LUMA) || (state == ST_CHROMA));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      qmat_we   <= 1'b0;
      qmat_sel  <= 1'b0;
      qmat_addr <= '0;
      qmat_data <= '0;
    end else begin
      qmat_we <= qmat_hit;
      if (qmat_hit) begin
        qmat_sel  <= (state == ST_CHROMA);
        qmat_addr <= byte_cnt[5:0];
        qmat_data <= in_data;
      end
    end
  end
`else
  assign qmat_we   = 1'b0;
  assign qmat_sel  = 1'b0;
  assign qmat_addr = '0;
  assign qmat_data = '0;
`endif

endmodule

// File: tb/tb_frame_header_parser.sv
// tb_frame_header_parser -- directed self-checking bench for frame_header_parser.
module tb_frame_header_parser;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready;
  logic [31:0] frame_size;
  logic [15:0] horizontal, vertical;
  logic [1:0]  chroma_format, interlace_mode;
  logic [3:0]  aspect_ratio_information, frame_rate_code, alpha_channel_type;
  logic [7:0]  color_primaries, transfer_characteristic, matrix_coefficients;
  logic        qmat_we, qmat_sel;
  logic [5:0]  qmat_addr;
  logic [7:0]  qmat_data;
  logic        header_valid, header_error;
  logic [1:0]  error_code;

`ifdef FRAME_HEADER_PARSER_QMAT_EN
  localparam int QW_FULL = 128;
`else
  localparam int QW_FULL = 0;
`endif

  frame_header_parser dut (
    .clock(clock), .reset_n(reset_n), .start(start),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .frame_size(frame_size), .horizontal(horizontal), .vertical(vertical),
    .chroma_format(chroma_format), .interlace_mode(interlace_mode),
    .aspect_ratio_information(aspect_ratio_information),
    .frame_rate_code(frame_rate_code), .alpha_channel_type(alpha_channel_type),
    .color_primaries(color_primaries),
    .transfer_characteristic(transfer_characteristic),
    .matrix_coefficients(matrix_coefficients),
    .qmat_we(qmat_we), .qmat_sel(qmat_sel), .qmat_addr(qmat_addr),
    .qmat_data(qmat_data), .header_valid(header_valid),
    .header_error(header_error), .error_code(error_code)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;
  int hv_cnt  = 0;
  int qw_cnt  = 0;
  int qerr    = 0;
  logic [7:0] hdr [156];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Output monitor: counts header_valid pulses and checks the qmat stream
  // order (64 luma then 64 chroma, addr = index, data = k+3).
  always @(negedge clock) begin
    if (header_valid) hv_cnt++;
    if (qmat_we) begin
      if (qmat_sel !== (qw_cnt >= 64) || qmat_addr !== 6'(qw_cnt % 64) ||
          qmat_data !== 8'(qw_cnt + 3))
        qerr++;
      qw_cnt++;
    end
  end

  task automatic clr();
    hv_cnt = 0; qw_cnt = 0; qerr = 0;
  endtask

  task automatic build(input logic [31:0] fsz, input logic [15:0] hsz, input logic [1:0] flags);
    hdr[0] = fsz[31:24]; hdr[1] = fsz[23:16]; hdr[2] = fsz[15:8]; hdr[3] = fsz[7:0];
    hdr[4] = 8'h69; hdr[5] = 8'h63; hdr[6] = 8'h70; hdr[7] = 8'h66;
    hdr[8] = hsz[15:8]; hdr[9] = hsz[7:0];
    hdr[10] = 8'h00; hdr[11] = 8'h00;
    hdr[12] = 8'h61; hdr[13] = 8'h70; hdr[14] = 8'h70; hdr[15] = 8'h6C;
    hdr[16] = 8'h07; hdr[17] = 8'h80;          // 1920
    hdr[18] = 8'h04; hdr[19] = 8'h38;          // 1080
    hdr[20] = 8'h84;                           // chroma 2, interlace 1
    hdr[21] = 8'h13;                           // aspect 1, rate 3
    hdr[22] = 8'h01; hdr[23] = 8'h02; hdr[24] = 8'h06;
    hdr[25] = 8'h02;                           // alpha 2
    hdr[26] = 8'h00;
    hdr[27] = {6'd0, flags};
    for (int k = 0; k < 128; k++) hdr[28 + k] = 8'(k + 3);
  endtask

  task automatic pulse_start();
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
  endtask

  // Present hdr[0..n-1]; gap=1 toggles in_valid 1,0. Returns #1 after the
  // negedge that follows the edge consuming the last byte.
  task automatic send(input int n, input bit gap);
    int idx = 0;
    int cyc = 0;
    bit tog = 1'b1;
    while (idx < n && cyc < 1000) begin
      @(negedge clock);
      in_valid = gap ? tog : 1'b1;
      tog = ~tog;
      in_data = hdr[idx];
      #1;
      if (in_valid && in_ready) idx++;
      cyc++;
    end
    @(negedge clock); in_valid = 1'b0;
    #1;
    check("send_bytes_accepted", idx, n);
  endtask

  task automatic settle();
    repeat (3) @(negedge clock);
    #1;
  endtask

  initial begin
    int rdy;
    repeat (3) @(negedge clock);
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_frame_size", frame_size, 0);
    check("rst_header_valid", header_valid, 0);
    check("rst_header_error", header_error, 0);
    check("rst_qmat_we", qmat_we, 0);
    @(negedge clock); reset_n = 1'b1;
    #1;
    check("idle_in_ready", in_ready, 0);

    // Full header, continuous valid
    build(32'd156, 16'd148, 2'b11);
    clr(); pulse_start(); send(156, 1'b0);
    check("full_hv_now", header_valid, 1);
    @(negedge clock); #1;
    check("full_hv_width", header_valid, 0);
    check("full_frame_size", frame_size, 32'd156);
    check("full_horizontal", horizontal, 16'd1920);
    check("full_vertical", vertical, 16'd1080);
    check("full_chroma", chroma_format, 2'd2);
    check("full_interlace", interlace_mode, 2'd1);
    check("full_aspect", aspect_ratio_information, 4'd1);
    check("full_rate", frame_rate_code, 4'd3);
    check("full_cp", color_primaries, 8'h01);
    check("full_tc", transfer_characteristic, 8'h02);
    check("full_mc", matrix_coefficients, 8'h06);
    check("full_alpha", alpha_channel_type, 4'd2);
    check("full_error", header_error, 0);
    check("full_done_ready", in_ready, 0);
    settle();
    check("full_hv_cnt", hv_cnt, 1);
    check("full_qw_cnt", qw_cnt, QW_FULL);
    check("full_qmat_order", qerr, 0);

    // Same header with in_valid gaps
    clr(); pulse_start(); send(156, 1'b1);
    check("gap_hv_now", header_valid, 1);
    check("gap_horizontal", horizontal, 16'd1920);
    check("gap_vertical", vertical, 16'd1080);
    check("gap_alpha", alpha_channel_type, 4'd2);
    settle();
    check("gap_hv_cnt", hv_cnt, 1);
    check("gap_qw_cnt", qw_cnt, QW_FULL);
    check("gap_qmat_order", qerr, 0);

    // Bad signature
    build(32'd156, 16'd148, 2'b11);
    hdr[4] = 8'h00;
    clr(); pulse_start(); send(8, 1'b0);
    check("sig_error", header_error, 1);
    check("sig_code", error_code, 2'd1);
    rdy = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock); in_valid = 1'b1; in_data = 8'hAA; #1;
      if (in_ready) rdy++;
    end
    in_valid = 1'b0;
    check("sig_no_ready", rdy, 0);
    check("sig_code_stable", error_code, 2'd1);
    settle();
    check("sig_hv_cnt", hv_cnt, 0);

    // No matrices, size 20
    build(32'd28, 16'd20, 2'b00);
    clr(); pulse_start(); send(28, 1'b0);
    check("nomat_hv_now", header_valid, 1);
    check("nomat_error_cleared", header_error, 0);
    settle();
    check("nomat_hv_cnt", hv_cnt, 1);
    check("nomat_qw_cnt", qw_cnt, 0);

    // No matrices, wrong size 148
    build(32'd28, 16'd148, 2'b00);
    clr(); pulse_start(); send(28, 1'b0);
    check("size_error", header_error, 1);
    check("size_code", error_code, 2'd2);
    settle();
    check("size_hv_cnt", hv_cnt, 0);
    check("size_ready", in_ready, 0);

    // Reset mid-LUMA at byte 50
    build(32'd156, 16'd148, 2'b11);
    clr(); pulse_start(); send(50, 1'b0);
    @(negedge clock); reset_n = 1'b0; #1;
    check("mrst_in_ready", in_ready, 0);
    check("mrst_frame_size", frame_size, 0);
    check("mrst_horizontal", horizontal, 0);
    check("mrst_chroma", chroma_format, 0);
    check("mrst_qmat_we", qmat_we, 0);
    check("mrst_qmat_addr", qmat_addr, 0);
    check("mrst_error", header_error, 0);
    @(negedge clock); reset_n = 1'b1; #1;
    check("mrst_idle_ready", in_ready, 0);
    clr(); pulse_start(); send(156, 1'b0);
    check("mrst_hv_now", header_valid, 1);
    settle();
    check("mrst_hv_cnt", hv_cnt, 1);
    check("mrst_qw_cnt", qw_cnt, QW_FULL);
    check("mrst_qmat_order", qerr, 0);

    // start mid-LUMA with a byte presented
    build(32'd156, 16'd148, 2'b11);
    pulse_start(); send(40, 1'b0);
    @(negedge clock); in_valid = 1'b1; in_data = hdr[40]; start = 1'b1; #1;
    check("restart_no_ready", in_ready, 0);
    @(negedge clock); start = 1'b0; in_valid = 1'b0;
    build(32'h12345678, 16'd148, 2'b11);
    clr(); send(156, 1'b0);
    check("restart_hv_now", header_valid, 1);
    check("restart_frame_size", frame_size, 32'h12345678);
    settle();
    check("restart_hv_cnt", hv_cnt, 1);
    check("restart_qw_cnt", qw_cnt, QW_FULL);
    check("restart_qmat_order", qerr, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
